// File: rtl/gf2_mul_pkg.sv
// Shared definitions for the GF(2) polynomial multipliers: FSM state encoding
// and the half-operand width helper.
package gf2_mul_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_MUL3 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic int unsigned half_w(input int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/ca_poly_mul.sv
// Combinational schoolbook carry-less multiplier, W x W -> 2W-1 bits.
module ca_poly_mul #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-2:0] p
);

    localparam int unsigned PW = 2 * W - 1;

    // XOR together shifted copies of a for every set bit of b.
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (b[i]) begin
                p = p ^ (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/oka_seq_mul.sv
// Sequential even/odd Karatsuba GF(2) multiplier: one shared half-width
// multiplier is reused over three cycles and the products folded into y.
module oka_seq_mul
    import gf2_mul_pkg::*;
#(
    parameter int unsigned N = 163
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);

    localparam int unsigned H  = half_w(N);
    localparam int unsigned AW = 2 * H;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned YW = 2 * N - 1;

    state_t        state_q;
    state_t        state_d;
    logic          load;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [YW-1:0] acc_q;

    logic [AW-1:0] a_pad;
    logic [AW-1:0] b_pad;
    logic [H-1:0]  ae;
    logic [H-1:0]  ao;
    logic [H-1:0]  be;
    logic [H-1:0]  bo;
    logic [H-1:0]  mul_a;
    logic [H-1:0]  mul_b;
    logic [PW-1:0] prod;
    logic [YW-1:0] sp;
    logic [YW-1:0] term;

    // Zero-extension to an even width gives the odd halves their padding bit.
    assign a_pad = AW'(a_q);
    assign b_pad = AW'(b_q);

    always_comb begin
        ae = '0;
        ao = '0;
        be = '0;
        bo = '0;
        for (int unsigned i = 0; i < H; i++) begin
            ae[i] = a_pad[2*i];
            ao[i] = a_pad[2*i+1];
            be[i] = b_pad[2*i];
            bo[i] = b_pad[2*i+1];
        end
    end

    // Select the half-product operands for the current multiply step.
    always_comb begin
        mul_a = ae;
        mul_b = be;
        case (state_q)
            S_MUL2: begin
                mul_a = ao;
                mul_b = bo;
            end
            S_MUL3: begin
                mul_a = ae ^ ao;
                mul_b = be ^ bo;
            end
            default: ;
        endcase
    end

    ca_poly_mul #(.W(H)) u_half_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Spread: every product bit lands on an even position, and always fits in YW.
    always_comb begin
        sp = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            sp[2*i] = prod[i];
        end
    end

    always_comb begin
        term = '0;
        case (state_q)
            S_MUL1:  term = sp ^ (sp << 1);
            S_MUL2:  term = (sp << 1) ^ (sp << 2);
            S_MUL3:  term = sp << 1;
            default: term = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = S_MUL1;
                end
            end
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_MUL3;
            S_MUL3:  state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Term is zero outside the multiply states, so the accumulator holds in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
            end else begin
                acc_q <= acc_q ^ term;
            end
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
        end
    end

    assign y = acc_q;

endmodule

// File: tb/tb_oka_seq_mul.sv
// Directed checks of oka_seq_mul at N=21, plus an exhaustive N=4 sweep with
// random output stalls against a bit-serial carry-less model.
module tb_oka_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv21, ir21, ov21, or21, busy21;
    logic [20:0] a21, b21;
    logic [40:0] y21;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [6:0]  y4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    oka_seq_mul #(.N(21)) dut21 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv21), .in_ready(ir21),
        .a(a21), .b(b21), .out_valid(ov21), .out_ready(or21),
        .y(y21), .busy(busy21)
    );

    oka_seq_mul #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .y(y4), .busy(busy4)
    );

    function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] z);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (z[i]) r = r ^ (64'(x) << i);
        end
        return r;
    endfunction

    // One N=21 transaction; operands are scrambled right after acceptance.
    task automatic run21(input logic [20:0] xa, input logic [20:0] xb,
                         output logic [40:0] yo, output int lat);
        int g;
        g = 0;
        while (!ir21 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        iv21 = 1'b1; a21 = xa; b21 = xb;
        @(posedge clk); #1;
        iv21 = 1'b0; a21 = ~xa; b21 = xb ^ 21'h15555;
        lat = 0;
        while (!ov21 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        yo = y21;
        or21 = 1'b1;
        @(posedge clk); #1;
        or21 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv21 = 1'b0; or21 = 1'b0; a21 = '0; b21 = '0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        tests++;
        if ({ir21, ov21, busy21} !== 3'b100 || y21 !== 41'd0) begin
            fails++;
            $display("FAIL reset21: ir/ov/busy=%b y=%h, required 100 y=0", {ir21, ov21, busy21}, y21);
        end
        tests++;
        if ({ir4, ov4, busy4} !== 3'b100 || y4 !== 7'd0) begin
            fails++;
            $display("FAIL reset4: ir/ov/busy=%b y=%h, required 100 y=0", {ir4, ov4, busy4}, y4);
        end
        // Operands presented across the release must be taken on the first edge.
        iv21 = 1'b1; a21 = 21'h1; b21 = 21'h1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        iv21 = 1'b0;
        tests++;
        if (busy21 !== 1'b1 || ir21 !== 1'b0) begin
            fails++;
            $display("FAIL first_accept: busy=%b in_ready=%b, required busy=1 in_ready=0", busy21, ir21);
        end
        for (int k = 0; k < 10 && !ov21; k++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (ov21 !== 1'b1 || y21 !== 41'h1) begin
            fails++;
            $display("FAIL first_product: out_valid=%b y=%h, required 1 y=1", ov21, y21);
        end
        or21 = 1'b1;
        @(posedge clk); #1;
        or21 = 1'b0;
    endtask

    task automatic test_directed();
        logic [20:0] va [8];
        logic [20:0] vb [8];
        logic [40:0] ve [8];
        logic [40:0] yo;
        int lat;
        va[0] = 21'h000001; vb[0] = 21'h000001; ve[0] = 41'h1;
        va[1] = 21'h000003; vb[1] = 21'h000003; ve[1] = 41'h5;
        va[2] = 21'h1FFFFF; vb[2] = 21'h000001; ve[2] = 41'h1FFFFF;
        va[3] = 21'h100000; vb[3] = 21'h100000; ve[3] = 41'h10000000000;
        va[4] = 21'h000005; vb[4] = 21'h000003; ve[4] = 41'hF;
        va[5] = 21'h000006; vb[5] = 21'h000006; ve[5] = 41'h14;
        va[6] = 21'h1FFFFF; vb[6] = 21'h1FFFFF; ve[6] = 41'h15555555555;
        va[7] = 21'h000002; vb[7] = 21'h100000; ve[7] = 41'h200000;
        for (int i = 0; i < 8; i++) begin
            run21(va[i], vb[i], yo, lat);
            tests++;
            if (yo !== ve[i]) begin
                fails++;
                $display("FAIL directed[%0d]: y=%h, required %h", i, yo, ve[i]);
            end
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL latency[%0d]: edges after accept=%0d, required 3", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] exp;
        int g;
        exp = 41'(clmul(32'h12345, 32'h0ABCD));
        iv21 = 1'b1; a21 = 21'h12345; b21 = 21'h0ABCD;
        @(posedge clk); #1;
        iv21 = 1'b0;
        g = 0;
        while (!ov21 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        for (int k = 0; k < 6; k++) begin
            iv21 = k[0]; a21 = 21'($urandom); b21 = 21'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({ov21, busy21, ir21} !== 3'b110 || y21 !== exp) begin
                fails++;
                $display("FAIL stall[%0d]: ov/busy/ir=%b y=%h, required 110 y=%h",
                         k, {ov21, busy21, ir21}, y21, exp);
            end
        end
        // Release and offer new operands in the same cycle: taken one cycle later.
        a21 = 21'h3; b21 = 21'h7; iv21 = 1'b1; or21 = 1'b1;
        @(posedge clk); #1;
        or21 = 1'b0;
        tests++;
        if ({ov21, busy21, ir21} !== 3'b001) begin
            fails++;
            $display("FAIL release_idle: ov/busy/ir=%b, required 001", {ov21, busy21, ir21});
        end
        @(posedge clk); #1;
        iv21 = 1'b0;
        tests++;
        if ({busy21, ir21} !== 2'b10) begin
            fails++;
            $display("FAIL release_accept: busy/ir=%b, required 10", {busy21, ir21});
        end
        g = 0;
        while (!ov21 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        tests++;
        if (ov21 !== 1'b1 || y21 !== 41'h9) begin
            fails++;
            $display("FAIL release_product: ov=%b y=%h, required 1 y=9", ov21, y21);
        end
        or21 = 1'b1;
        @(posedge clk); #1;
        or21 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [40:0] yo;
        int lat;
        iv21 = 1'b1; a21 = 21'h1FFFFF; b21 = 21'h1FFFFF;
        @(posedge clk); #1;
        iv21 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ov21, busy21, ir21} !== 3'b001 || y21 !== 41'd0) begin
            fails++;
            $display("FAIL reset_mid: ov/busy/ir=%b y=%h, required 001 y=0", {ov21, busy21, ir21}, y21);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run21(21'h7, 21'h7, yo, lat);
        tests++;
        if (yo !== 41'h15 || lat !== 3) begin
            fails++;
            $display("FAIL after_reset: y=%h lat=%0d, required y=15 lat=3", yo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] yo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            logic [20:0] xa, xb;
            xa = 21'($urandom);
            xb = 21'($urandom);
            run21(xa, xb, yo, lat);
            tests++;
            if (yo !== 41'(clmul(32'(xa), 32'(xb)))) begin
                fails++;
                $display("FAIL b2b[%0d]: a=%h b=%h y=%h, required %h",
                         i, xa, xb, yo, 41'(clmul(32'(xa), 32'(xb))));
            end
        end
    endtask

    task automatic test_n4_sweep();
        int g;
        logic [6:0] exp;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp = 7'(clmul(32'(i), 32'(j)));
                iv4 = 1'b1; a4 = 4'(i); b4 = 4'(j);
                @(posedge clk); #1;
                iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                g = 0;
                while (!ov4 && g < 20) begin
                    @(posedge clk); #1; g++;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                tests++;
                if (ov4 !== 1'b1 || y4 !== exp) begin
                    fails++;
                    $display("FAIL n4 a=%0d b=%0d: ov=%b y=%h, required 1 y=%h", i, j, ov4, y4, exp);
                end
                or4 = 1'b1;
                @(posedge clk); #1;
                or4 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_n4_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
